// File: rtl/bidir_fifo_test_ctrl.sv
// Sequencer for one bidirectional pipe-in/pipe-out FIFO throughput test.
// Gates pipe strobes into FIFO enables, tracks occupancy, times and reports.
module bidir_fifo_test_ctrl #(
  parameter int unsigned FIFO_DEPTH    = 2048,
  parameter int unsigned LEVEL_W       = 12,
  parameter int unsigned FLUSH_CYCLES  = 4,
  parameter int unsigned DRAIN_TIMEOUT = 100_000_000
) (
  input  logic               okClk,
  input  logic               reset,
  input  logic               cmd_start,
  input  logic               cmd_stop,
  input  logic [31:0]        xfer_len,
  input  logic               pipe_in_write,
  input  logic               pipe_out_read,
  output logic               fifo_rst,
  output logic               fifo_wr_en,
  output logic               fifo_rd_en,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic [63:0]        clk_counts,
  output logic [31:0]        words_in,
  output logic [31:0]        words_out,
  output logic [31:0]        status
);

  localparam int unsigned FW =
    (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned TW = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [LEVEL_W-1:0] DEPTH_L = LEVEL_W'(FIFO_DEPTH);
  localparam logic [FW-1:0]      FL_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [TW-1:0]      TO_L    = TW'(DRAIN_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        xfer_q, xfer_d;
  logic [FW-1:0]      flush_q, flush_d;
  logic [TW-1:0]      tout_q, tout_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [63:0]        clk_q, clk_d;
  logic [31:0]        win_q, win_d;
  logic [31:0]        wout_q, wout_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic               tmo_q, tmo_d;
  logic               abt_q, abt_d;
  logic               done_q, done_d;

  logic               run, drn;
  logic               wr_en, rd_en;
  logic               ovf_ev, udf_ev, tmo_ev;

  // State and datapath registers; async reset clears the whole test.
  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      xfer_q  <= '0;
      flush_q <= '0;
      tout_q  <= '0;
      level_q <= '0;
      clk_q   <= '0;
      win_q   <= '0;
      wout_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      abt_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xfer_q  <= xfer_d;
      flush_q <= flush_d;
      tout_q  <= tout_d;
      level_q <= level_d;
      clk_q   <= clk_d;
      win_q   <= win_d;
      wout_q  <= wout_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      tmo_q   <= tmo_d;
      abt_q   <= abt_d;
      done_q  <= done_d;
    end
  end

  // Strobe gating, counters and next-state selection.
  always_comb begin
    state_d = state_q;
    xfer_d  = xfer_q;
    flush_d = flush_q;
    tout_d  = tout_q;
    level_d = level_q;
    clk_d   = clk_q;
    win_d   = win_q;
    wout_d  = wout_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    tmo_d   = tmo_q;
    abt_d   = abt_q;
    done_d  = done_q;

    run    = (state_q == S_RUN);
    drn    = (state_q == S_DRAIN);
    wr_en  = run & pipe_in_write & (level_q < DEPTH_L);
    rd_en  = (run | drn) & pipe_out_read & (level_q != '0);
    ovf_ev = run & pipe_in_write & (level_q == DEPTH_L);
    udf_ev = (run | drn) & pipe_out_read & (level_q == '0);
    tmo_ev = drn & ~rd_en & ((tout_q + TW'(1)) == TO_L);

    if (wr_en) win_d = win_q + 32'd1;
    if (rd_en) wout_d = wout_q + 32'd1;
    if (wr_en && !rd_en) level_d = level_q + LEVEL_W'(1);
    if (rd_en && !wr_en) level_d = level_q - LEVEL_W'(1);
    if (run || drn) clk_d = clk_q + 64'd1;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (cmd_start) begin
          state_d = S_FLUSH;
          xfer_d  = xfer_len;
          flush_d = '0;
          tout_d  = '0;
          level_d = '0;
          clk_d   = '0;
          win_d   = '0;
          wout_d  = '0;
          ovf_d   = 1'b0;
          udf_d   = 1'b0;
          tmo_d   = 1'b0;
          abt_d   = 1'b0;
          done_d  = 1'b0;
        end
      end
      S_FLUSH: begin
        clk_d = '0;
        if (flush_q == FL_LAST) begin
          state_d = S_RUN;
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end
      S_RUN: begin
        if (cmd_stop) begin
          state_d = S_DONE;
          abt_d   = 1'b1;
          done_d  = 1'b1;
        end else if (ovf_ev || udf_ev) begin
          state_d = S_ERROR;
          ovf_d   = ovf_ev;
          udf_d   = udf_ev;
        end else if (wr_en && xfer_q != '0 &&
                     (win_q + 32'd1) == xfer_q) begin
          state_d = S_DRAIN;
          tout_d  = '0;
        end
      end
      S_DRAIN: begin
        tout_d = rd_en ? '0 : tout_q + TW'(1);
        if (cmd_stop) begin
          state_d = S_DONE;
          abt_d   = 1'b1;
          done_d  = 1'b1;
        end else if (udf_ev || tmo_ev) begin
          state_d = S_ERROR;
          udf_d   = udf_ev;
          tmo_d   = tmo_ev;
        end else if (rd_en && (wout_q + 32'd1) == xfer_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fifo_rst   = reset | (state_q == S_FLUSH);
  assign fifo_wr_en = wr_en;
  assign fifo_rd_en = rd_en;
  assign fifo_level = level_q;
  assign clk_counts = clk_q;
  assign words_in   = win_q;
  assign words_out  = wout_q;
  assign status     = 32'({level_q, 8'b0, done_q, abt_q, tmo_q,
                           udf_q, ovf_q, state_q});

endmodule

// File: tb/tb_bidir_fifo_test_ctrl.sv
// Bench for bidir_fifo_test_ctrl: directed scenarios plus random traffic,
// every cycle compared against a queue-free arithmetic reference model.
module tb_bidir_fifo_test_ctrl;

  localparam int DEPTH = 2048;
  localparam int TOUT  = 16;

  logic        okClk = 1'b0;
  logic        reset;
  logic        cmd_start, cmd_stop;
  logic [31:0] xfer_len;
  logic        pipe_in_write, pipe_out_read;
  logic        fifo_rst, fifo_wr_en, fifo_rd_en;
  logic [11:0] fifo_level;
  logic [63:0] clk_counts;
  logic [31:0] words_in, words_out, status;

  int checks   = 0;
  int failures = 0;

  // reference model
  int              mst;
  int unsigned     mx, mwin, mwout, mfl, mq;
  int              mlev;
  longint unsigned mclk;
  bit              movf, mudf, mtmo, mabt, mdone;

  bidir_fifo_test_ctrl #(
    .FIFO_DEPTH(DEPTH),
    .LEVEL_W(12),
    .FLUSH_CYCLES(4),
    .DRAIN_TIMEOUT(TOUT)
  ) dut (
    .okClk(okClk),
    .reset(reset),
    .cmd_start(cmd_start),
    .cmd_stop(cmd_stop),
    .xfer_len(xfer_len),
    .pipe_in_write(pipe_in_write),
    .pipe_out_read(pipe_out_read),
    .fifo_rst(fifo_rst),
    .fifo_wr_en(fifo_wr_en),
    .fifo_rd_en(fifo_rd_en),
    .fifo_level(fifo_level),
    .clk_counts(clk_counts),
    .words_in(words_in),
    .words_out(words_out),
    .status(status)
  );

  always #5 okClk = ~okClk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mst = 0; mx = 0; mwin = 0; mwout = 0; mfl = 0; mq = 0;
    mlev = 0; mclk = 0;
    movf = 0; mudf = 0; mtmo = 0; mabt = 0; mdone = 0;
  endtask

  function automatic logic [31:0] exp_status();
    return (32'(mlev) << 16) | (32'(mdone) << 7) | (32'(mabt) << 6) |
           (32'(mtmo) << 5) | (32'(mudf) << 4) | (32'(movf) << 3) |
           32'(mst);
  endfunction

  // One clock cycle: drive, compare against model, advance model.
  task automatic cycle(input bit sa, input bit st, input logic [31:0] len,
                       input bit w, input bit r);
    bit ewr, erd, ovfe, udfe, busy;
    int ost;
    cmd_start = sa; cmd_stop = st; xfer_len = len;
    pipe_in_write = w; pipe_out_read = r;
    #1;
    ost  = mst;
    busy = (ost == 2) || (ost == 3);
    ewr  = (ost == 2) && w && (mlev < DEPTH);
    erd  = busy && r && (mlev > 0);
    ovfe = (ost == 2) && w && (mlev == DEPTH);
    udfe = busy && r && (mlev == 0);
    chk("fifo_wr_en", 64'(fifo_wr_en), 64'(ewr));
    chk("fifo_rd_en", 64'(fifo_rd_en), 64'(erd));
    chk("fifo_rst", 64'(fifo_rst), 64'(ost == 1));
    chk("fifo_level", 64'(fifo_level), 64'(mlev));
    chk("clk_counts", clk_counts, mclk);
    chk("words_in", 64'(words_in), 64'(mwin));
    chk("words_out", 64'(words_out), 64'(mwout));
    chk("status", 64'(status), 64'(exp_status()));
    if (ewr) mwin++;
    if (erd) mwout++;
    mlev = mlev + int'(ewr) - int'(erd);
    if (busy) mclk++;
    case (ost)
      0, 4, 5: if (sa) begin
        model_reset();
        mst = 1; mx = len;
      end
      1: begin
        mfl++;
        if (mfl == 4) mst = 2;
      end
      2: begin
        if (st) begin
          mst = 4; mabt = 1; mdone = 1;
        end else if (ovfe || udfe) begin
          mst = 5; movf = ovfe; mudf = udfe;
        end else if (ewr && mx != 0 && mwin == mx) begin
          mst = 3; mq = 0;
        end
      end
      3: begin
        mq = erd ? 0 : mq + 1;
        if (st) begin
          mst = 4; mabt = 1; mdone = 1;
        end else if (udfe || mq == TOUT) begin
          mst = 5; mudf = udfe; mtmo = (mq == TOUT);
        end else if (erd && mwout == mx) begin
          mst = 4; mdone = 1;
        end
      end
      default: ;
    endcase
    @(posedge okClk);
    @(negedge okClk);
  endtask

  task automatic start(input logic [31:0] len);
    cycle(1, 0, len, 0, 0);
    repeat (4) cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    cmd_start = 0; cmd_stop = 0; xfer_len = 0;
    pipe_in_write = 0; pipe_out_read = 0;
    #1;
    chk("rst_state", 64'(status), 64'd0);
    chk("rst_fifo_rst", 64'(fifo_rst), 64'd1);
    chk("rst_clk_counts", clk_counts, 64'd0);
    @(negedge okClk);
    reset = 1'b0;
    cycle(0, 0, 0, 1, 1);

    // 1: bounded transfer of 8 words each way
    start(8);
    chk("t1_run", 64'(status[2:0]), 64'd2);
    repeat (8) cycle(0, 0, 0, 1, 0);
    chk("t1_drain", 64'(status[2:0]), 64'd3);
    repeat (8) cycle(0, 0, 0, 0, 1);
    chk("t1_done", 64'(status[2:0]), 64'd4);
    chk("t1_win", 64'(words_in), 64'd8);
    chk("t1_wout", 64'(words_out), 64'd8);
    chk("t1_level", 64'(fifo_level), 64'd0);
    chk("t1_done_bit", 64'(status[7]), 64'd1);
    cycle(0, 0, 0, 0, 0);

    // 2: overflow on write 2049
    start(0);
    repeat (DEPTH) cycle(0, 0, 0, 1, 0);
    pipe_in_write = 1; #1;
    chk("t2_wr_en_full", 64'(fifo_wr_en), 64'd0);
    cycle(0, 0, 0, 1, 0);
    chk("t2_state", 64'(status[2:0]), 64'd5);
    chk("t2_ovf", 64'(status[3]), 64'd1);
    chk("t2_level", 64'(fifo_level), 64'd2048);
    repeat (3000 - DEPTH - 1) cycle(0, 0, 0, 1, 0);
    chk("t2_win", 64'(words_in), 64'd2048);

    // 3: underflow on read at empty
    start(5);
    pipe_out_read = 1; #1;
    chk("t3_rd_en_empty", 64'(fifo_rd_en), 64'd0);
    cycle(0, 0, 0, 0, 1);
    chk("t3_state", 64'(status[2:0]), 64'd5);
    chk("t3_udf", 64'(status[4]), 64'd1);
    chk("t3_wout", 64'(words_out), 64'd0);

    // 4: stop beats start in RUN; duration frozen
    start(0);
    repeat (5) cycle(0, 0, 0, 1, 0);
    cycle(1, 1, 0, 0, 0);
    chk("t4_state", 64'(status[2:0]), 64'd4);
    chk("t4_aborted", 64'(status[6]), 64'd1);
    repeat (3) cycle(0, 0, 0, 1, 1);
    chk("t4_clk_frozen", clk_counts, 64'd6);

    // 5: simultaneous write and read at level 10
    start(0);
    repeat (10) cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 1);
    chk("t5_level", 64'(fifo_level), 64'd10);
    chk("t5_win", 64'(words_in), 64'd11);
    chk("t5_wout", 64'(words_out), 64'd1);
    cycle(0, 1, 0, 0, 0);

    // 6: drain timeout, then async reset mid-run
    start(4);
    repeat (4) cycle(0, 0, 0, 1, 0);
    chk("t6_drain", 64'(status[2:0]), 64'd3);
    repeat (TOUT - 1) cycle(0, 0, 0, 0, 0);
    chk("t6_still_drain", 64'(status[2:0]), 64'd3);
    cycle(0, 0, 0, 0, 0);
    chk("t6_error", 64'(status[2:0]), 64'd5);
    chk("t6_timeout", 64'(status[5]), 64'd1);
    start(0);
    repeat (5) cycle(0, 0, 0, 1, 0);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_state", 64'(status[2:0]), 64'd0);
    chk("rst_mid_fifo_rst", 64'(fifo_rst), 64'd1);
    chk("rst_mid_win", 64'(words_in), 64'd0);
    model_reset();
    @(posedge okClk);
    @(negedge okClk);
    reset = 1'b0;
    cycle(0, 0, 0, 0, 0);

    // random traffic
    for (int t = 0; t < 60; t++) begin
      logic [31:0] len;
      len = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
      cycle(1, 0, len, 0, 0);
      for (int c = 0; c < 150; c++) begin
        bit w, r, sa, st;
        w  = $urandom_range(0, 99) < 45;
        r  = $urandom_range(0, 99) < ((mlev > 0) ? 45 : 2);
        sa = $urandom_range(0, 299) == 0;
        st = $urandom_range(0, 299) == 0;
        cycle(sa, st, $urandom, w, r);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
